// File: rtl/snd_req_arbiter.sv
// -----------------------------------------------------------------------------
// snd_req_arbiter
//   Shares the single sndm sound player among several independent requesters.
//   One-cycle requests are latched into pending bits (with their sound mode)
//   so none are lost while a sound plays. The arbiter issues exactly one
//   snd_trig/grant pulse per granted request and follows sndm's playing flag,
//   then inserts a silence gap before the next trigger.
//
//   Optional build macro: SND_REQ_ARB_RR_EN
//     defined   -> round-robin winner selection (search starts at rr_ptr)
//     undefined -> fixed priority, index 0 highest (no rr_ptr register)
//
// Ports
//   clk_1mhz     in   system clock (1 MHz)
//   rst          in   synchronous active-high reset
//   req          in   per-requester request pulse (a level re-requests)
//   req_mode     in   3-bit mode per requester, requester i at [3i+2:3i]
//   flush        in   drop all pending requests (beats a same-cycle req)
//   snd_playing  in   sndm busy flag
//   snd_trig     out  one-cycle trigger to sndm
//   snd_mode     out  mode to sndm, held from one grant to the next
//   grant        out  one-hot grant pulse, coincident with snd_trig
//   pending      out  registered pending bits
//   overwrite    out  pulse when a pending request is re-requested
//   timeout_err  out  pulse when snd_playing never rose after a trigger
//   busy         out  high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module snd_req_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned GAP_CYCLES    = 20000,
  parameter int unsigned START_TIMEOUT = 1000
) (
  input  logic                   clk_1mhz,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [3*NUM_REQ-1:0]   req_mode,
  input  logic                   flush,
  input  logic                   snd_playing,
  output logic                   snd_trig,
  output logic [2:0]             snd_mode,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     pending,
  output logic                   overwrite,
  output logic                   timeout_err,
  output logic                   busy
);

  localparam int unsigned CNT_MAX = (GAP_CYCLES > START_TIMEOUT) ? GAP_CYCLES : START_TIMEOUT;
  localparam int unsigned CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam int unsigned IDX_W   = (NUM_REQ < 2) ? 1 : $clog2(NUM_REQ);

  localparam logic [CNT_W-1:0] C_GAP    = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] C_TO     = CNT_W'(START_TIMEOUT);
  localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);
  localparam bit               GAP_EN   = (GAP_CYCLES != 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_START = 2'd1,
    S_WAIT_END   = 2'd2,
    S_GAP        = 2'd3
  } state_t;

  state_t             r_state;
  logic [NUM_REQ-1:0] r_pend;
  logic [2:0]         r_mode_q [NUM_REQ];
  logic [CNT_W-1:0]   r_cnt;

  logic [IDX_W-1:0]   w_base;
  logic [IDX_W-1:0]   w_cand;
  logic [IDX_W-1:0]   w_win_idx;
  logic               w_win_vld;
  logic               w_do_grant;
  logic               w_ovr;
  logic               w_cnt_last;
  logic [NUM_REQ-1:0] w_grant_vec;
  logic [NUM_REQ-1:0] w_pend_nxt;

  assign pending = r_pend;

  // Counter at 1 (or 0 for a degenerate load) is the final cycle of a wait.
  assign w_cnt_last = (r_cnt == '0) || (r_cnt == C_ONE);

`ifdef SND_REQ_ARB_RR_EN
  logic [IDX_W-1:0] r_rr_ptr;
  assign w_base = r_rr_ptr;
`else
  assign w_base = '0;
`endif

  // Winner search: first set pending bit starting at w_base, wrapping.
  always_comb begin
    w_win_idx = '0;
    w_win_vld = 1'b0;
    w_cand    = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      w_cand = IDX_W'((int'(w_base) + k) % int'(NUM_REQ));
      if (!w_win_vld && r_pend[w_cand]) begin
        w_win_vld = 1'b1;
        w_win_idx = w_cand;
      end
    end
  end

  // Pending bookkeeping. A flush suppresses a grant in the same cycle so a
  // flushed request can never be played.
  always_comb begin
    w_grant_vec = '0;
    w_do_grant  = (r_state == S_IDLE) && w_win_vld && !flush;
    if (w_do_grant) begin
      w_grant_vec[w_win_idx] = 1'b1;
    end
    w_pend_nxt = (r_pend & ~w_grant_vec) | req;
    if (flush) begin
      w_pend_nxt = '0;
    end
    // Re-requesting the index being granted right now loses nothing.
    w_ovr = !flush && (|(req & r_pend & ~w_grant_vec));
  end

  // Sequencer and registered outputs.
  always_ff @(posedge clk_1mhz) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pend      <= '0;
      r_cnt       <= '0;
      snd_trig    <= 1'b0;
      snd_mode    <= '0;
      grant       <= '0;
      overwrite   <= 1'b0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        r_mode_q[i] <= '0;
      end
`ifdef SND_REQ_ARB_RR_EN
      r_rr_ptr    <= '0;
`endif
    end else begin
      r_pend      <= w_pend_nxt;
      overwrite   <= w_ovr;
      snd_trig    <= 1'b0;
      grant       <= '0;
      timeout_err <= 1'b0;

      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (req[i] && !flush) begin
          r_mode_q[i] <= req_mode[3*i +: 3];
        end
      end

      case (r_state)
        S_IDLE: begin
          if (w_do_grant) begin
            snd_trig <= 1'b1;
            grant    <= w_grant_vec;
            snd_mode <= r_mode_q[w_win_idx];
            r_cnt    <= C_TO;
            r_state  <= S_WAIT_START;
            busy     <= 1'b1;
`ifdef SND_REQ_ARB_RR_EN
            r_rr_ptr <= (w_win_idx == IDX_LAST) ? '0 : w_win_idx + IDX_W'(1);
`endif
          end
        end

        S_WAIT_START: begin
          if (snd_playing) begin
            r_cnt   <= '0;
            r_state <= S_WAIT_END;
          end else if (w_cnt_last) begin
            timeout_err <= 1'b1;
            if (GAP_EN) begin
              r_cnt   <= C_GAP;
              r_state <= S_GAP;
            end else begin
              r_cnt   <= '0;
              r_state <= S_IDLE;
              busy    <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt - C_ONE;
          end
        end

        S_WAIT_END: begin
          if (!snd_playing) begin
            if (GAP_EN) begin
              r_cnt   <= C_GAP;
              r_state <= S_GAP;
            end else begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
            end
          end
        end

        S_GAP: begin
          if (w_cnt_last) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            r_cnt <= r_cnt - C_ONE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/snd_req_arbiter.md
Name: snd_req_arbiter

Overview:
- Shares the single sound player (sndm) among several independent sound requesters, e.g. hit/miss, countdown beeps, stage/game-end jingles.
- Latches one-cycle requests so none are lost while a sound is playing.
- Picks one winner and issues exactly one snd_trig/snd_mode pulse per grant.
- Tracks sndm's playing flag to sequence back-to-back sounds with an optional silence gap.
- Sits between the game main FSM and sndm, replacing ad-hoc trig/mode handling.

Parameters:
- NUM_REQ, 4, number of requesters (2..8); index 0 is the highest fixed priority.
- GAP_CYCLES, 20000, clk_1mhz cycles of silence after a sound ends before the next trigger; 0 means no gap.
- START_TIMEOUT, 1000, cycles to wait for snd_playing to rise after a trigger before abandoning.

Ports:
- clk_1mhz  in  1  system clock, 1 MHz.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester one-cycle request pulse (a level is also accepted; it re-requests every cycle).
- req_mode  in  3*NUM_REQ  sound mode for requester i at bits [3i+2:3i]; sampled in the cycle req[i] is high.
- flush  in  1  clears all pending requests; does not affect a sound already triggered.
- snd_playing  in  1  sndm busy flag, same clock domain.
- snd_trig  out  1  one-cycle trigger to sndm.
- snd_mode  out  3  mode to sndm; held stable from the trigger until the next grant.
- grant  out  NUM_REQ  one-hot, one-cycle pulse coincident with snd_trig.
- pending  out  NUM_REQ  registered pending bits.
- overwrite  out  1  one-cycle pulse when req[i] arrives while pending[i] is already set.
- timeout_err  out  1  one-cycle pulse when START_TIMEOUT expires.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset and clock:
  - All sequential logic is clocked on posedge clk_1mhz, with synchronous active-high rst.
  - Reset values: every output is 0, state is IDLE, all pending bits are 0, all counters are 0, the stored modes are 0, and the RR pointer is 0.
- Request latching:
  - At each edge, for each i: if req[i], then pend[i] is set to 1 and mode_q[i] takes req_mode[i]. If pend[i] was already 1, the new mode overwrites the old one and overwrite pulses.
  - If flush is high, all pend bits are cleared. flush beats a same-cycle req, so that req is dropped.
- State IDLE:
  - If any pend bit is set, select winner w. Without RR_EN, w is the lowest set index.
  - At that edge: snd_trig=1, grant[w]=1, snd_mode=mode_q[w], pend[w] cleared (unless req[w] is high in the same cycle, in which case it stays set with the new mode). Go to WAIT_START and load the timeout counter.
  - Latency: req high in cycle 0 gives pend in cycle 1, and snd_trig/grant in cycle 2.
- State WAIT_START:
  - snd_trig returns to 0.
  - If snd_playing=1, go to WAIT_END.
  - Otherwise decrement the counter. When it reaches 0 after START_TIMEOUT cycles, pulse timeout_err and go to GAP.
- State WAIT_END:
  - When snd_playing=0, go to GAP and load the gap counter with GAP_CYCLES.
  - If GAP_CYCLES=0, go directly to IDLE.
- State GAP:
  - Decrement the counter; go to IDLE when it reaches 1 → 0, giving exactly GAP_CYCLES cycles in GAP.
- Pending during a sound: requests arriving in WAIT_START, WAIT_END or GAP only set pend. They are granted on the first IDLE cycle.
- Single-outstanding rule: at most one trigger is outstanding; snd_trig never pulses outside the IDLE → WAIT_START edge.
- Mode hold: snd_mode never changes except at a grant.
- Counter widths: $clog2(max(GAP_CYCLES, START_TIMEOUT)+1) bits; no wrap-around is permitted.
- Reset mid-operation: everything returns to reset values and pending requests are lost. sndm is reset separately by the same rst.
- busy is high in WAIT_START, WAIT_END and GAP.

Optional Feature:
- SND_REQ_ARB_RR_EN: when defined, the winner is chosen round-robin.
  - Search starts at the index after the last grant (rr_ptr), wrapping at NUM_REQ-1 → 0.
  - rr_ptr updates at each grant to w+1 mod NUM_REQ.
- When undefined: fixed priority, index 0 highest; no rr_ptr register exists.

Test Plan:
1. GAP_CYCLES=10. req[1] pulse with mode 3'b011 in cycle 0 → pend[1] in cycle 1; snd_trig=1, grant=4'b0010, snd_mode=3'b011 in cycle 2. Model snd_playing high for 50 cycles → busy stays high until 10 cycles after snd_playing falls.
2. req[0]=mode 3'b100 and req[2]=mode 3'b001 in the same cycle → without RR, grant[0] first, grant[2] after the first sound ends plus the gap. With RR_EN and rr_ptr=1, grant[2] comes first.
3. req[3] mode 3'b001, then req[3] mode 3'b010 two cycles later while playing → overwrite pulses once; the next grant carries snd_mode 3'b010; only one trigger is issued for requester 3.
4. Trigger issued, snd_playing held low → timeout_err pulses exactly START_TIMEOUT cycles after the trigger; the state passes through GAP; a pending request is then granted normally.
5. Two requests pending during playback, then flush → pending=0; no further snd_trig after the current sound ends. flush and req[1] in the same cycle → req[1] dropped.
6. rst asserted in WAIT_END with pend=4'b0101 → the next cycle shows all outputs 0, state IDLE, pending=0, and no snd_trig.
